// File: rtl/exp5_unidade_controle_timeout.sv
// Moore control unit for the exp5 memory game: sequences rounds and plays and
// enforces a per-play response window with an internal timeout counter.
module exp5_unidade_controle_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimR,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraR,
  output logic       contaR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    Inicial      = 4'h0,
    Preparacao   = 4'h1,
    InicioRodada = 4'h2,
    Espera       = 4'h3,
    Registra     = 4'h4,
    Comparacao   = 4'h5,
    ProxJogada   = 4'h6,
    ProxRodada   = 4'h7,
    FimAcertou   = 4'hA,
    FimTimeout   = 4'hD,
    FimErrou     = 4'hE
  } estado_e;

  estado_e         estado_q, estado_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;

  assign timeout = (estado_q == Espera) && (cnt_q == CntLast);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= Inicial;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      Inicial:      if (iniciar) estado_d = Preparacao;
      Preparacao:   estado_d = InicioRodada;
      InicioRodada: estado_d = Espera;
      // A press in the last window cycle still counts: jogada beats timeout.
      Espera: begin
        if (jogada)       estado_d = Registra;
        else if (timeout) estado_d = FimTimeout;
      end
      Registra:     estado_d = Comparacao;
      Comparacao: begin
        if (!igual)     estado_d = FimErrou;
        else if (!fimE) estado_d = ProxJogada;
        else if (!fimR) estado_d = ProxRodada;
        else            estado_d = FimAcertou;
      end
      ProxJogada:   estado_d = Espera;
      ProxRodada:   estado_d = InicioRodada;
      FimAcertou, FimErrou, FimTimeout: if (iniciar) estado_d = Preparacao;
      default:      estado_d = Inicial;
    endcase
  end

  // Counts only while remaining in Espera, so every entry starts a fresh window at 0.
  always_comb begin
    cnt_d = '0;
    if ((estado_q == Espera) && (estado_d == Espera)) cnt_d = cnt_q + CntW'(1);
  end

  always_comb begin
    zeraE      = 1'b0;
    contaE     = 1'b0;
    zeraR      = 1'b0;
    contaR     = 1'b0;
    registraR  = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    pronto     = 1'b0;
    db_timeout = 1'b0;
    unique case (estado_q)
      Preparacao: begin
        zeraE = 1'b1;
        zeraR = 1'b1;
      end
      InicioRodada: zeraE     = 1'b1;
      Registra:     registraR = 1'b1;
      ProxJogada:   contaE    = 1'b1;
      ProxRodada:   contaR    = 1'b1;
      FimAcertou: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FimErrou: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FimTimeout: begin
        pronto     = 1'b1;
        errou      = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_exp5_unidade_controle_timeout.sv
// Directed bench for exp5_unidade_controle_timeout: expected state/output words are
// queued as each step is driven and popped when the step's clock edge has passed.
module tb_exp5_unidade_controle_timeout;

  localparam int unsigned TO = 20;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada, igual, fimE, fimR;
  logic       zeraE, contaE, zeraR, contaR, registraR, acertou, errou, pronto, db_timeout;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];

  exp5_unidade_controle_timeout #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .fimE(fimE), .fimR(fimR), .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR),
    .contaR(contaR), .registraR(registraR), .acertou(acertou), .errou(errou),
    .pronto(pronto), .db_timeout(db_timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // {zeraE, contaE, zeraR, contaR, registraR, acertou, errou, pronto, db_timeout}
  function automatic logic [8:0] outs_of(input logic [3:0] st);
    case (st)
      4'h1:    return 9'b101000000;
      4'h2:    return 9'b100000000;
      4'h4:    return 9'b000010000;
      4'h6:    return 9'b010000000;
      4'h7:    return 9'b000100000;
      4'hA:    return 9'b000001010;
      4'hE:    return 9'b000000110;
      4'hD:    return 9'b000000111;
      default: return 9'b000000000;
    endcase
  endfunction

  task automatic expect_state(input logic [3:0] st);
    exp_q.push_back({st, outs_of(st)});
  endtask

  task automatic check(input string tag);
    logic [12:0] got, want;
    got = {db_estado, zeraE, contaE, zeraR, contaR, registraR, acertou, errou, pronto,
           db_timeout};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %h with no expected entry queued", tag, got);
    end else begin
      want = exp_q.pop_front();
      assert (got === want)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
    end
  endtask

  task automatic step(input logic ini, input logic jog, input logic ig, input logic fe,
                      input logic fr, input logic [3:0] st, input string tag);
    iniciar = ini;
    jogada  = jog;
    igual   = ig;
    fimE    = fe;
    fimR    = fr;
    expect_state(st);
    @(posedge clock);
    #1;
    check(tag);
  endtask

  // One correct play at position p of round r, after wt idle cycles in Espera.
  task automatic play(input int r, input int p, input int wt);
    logic       fe, fr;
    logic [3:0] nxt;
    for (int i = 0; i < wt; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, "espera_hold");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, "registra");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, "comparacao");
    fe  = (p == r);
    fr  = (r == 15);
    nxt = !fe ? 4'h6 : (fr ? 4'hA : 4'h7);
    step(1'b0, 1'b0, 1'b1, fe, fr, nxt, "decide");
    if (nxt == 4'h6) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, "prox_jogada_espera");
    end else if (nxt == 4'h7) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, "prox_rodada_inicio");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, "prox_rodada_espera");
    end
  endtask

  task automatic start_game(input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, "inicio_rodada");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, "espera");
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimE = 1'b0; fimR = 1'b0;
    @(posedge clock);
    #1;
    expect_state(4'h0);
    check("reset_state");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, "idle");
    // Press while idle is ignored.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, "idle_jogada");

    // Rounds 0 and 1; iniciar stays high through the start and must not re-trigger.
    start_game("preparacao");
    play(0, 0, 0);
    play(1, 0, 15);
    play(1, 1, TO - 1);

    // Round 2: no press for the whole window.
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, "window");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD, "timeout");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD, "timeout_hold");

    // Restart, then press on the last window cycle: press wins, then wrong button.
    start_game("restart_timeout");
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, "window2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, "late_jogada");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, "comparacao_err");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hE, "errou");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hE, "errou_hold");
    start_game("restart_errou");

    // Full game of 16 rounds.
    for (int r = 0; r < 16; r++)
      for (int p = 0; p <= r; p++) play(r, p, (r + p) % 3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, "acertou_hold");

    // Async reset mid-window, between clock edges.
    start_game("restart_acertou");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, "pre_reset");
    #2 reset = 1'b1;
    #1;
    expect_state(4'h0);
    check("async_reset");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, "reset_held");
    reset = 1'b0;

    // Counter must come back cleared: the full window applies again.
    start_game("after_reset");
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, "window3");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD, "timeout_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
